psram_axi4_rd_slv_buf: RTL and testbench

Parametrised AXI4 read-only slave for the PSRAM controller. It replaces the read path of the current combined slave FSM and adds the following:
- WRAP burst address generation.
- A FIFO_DEPTH-entry read-data buffer, so R-channel backpressure never drops user-side data.
- Protocol and range checking with error responses.

It sits between the AXI4 interconnect and the PSRAM user interface; the write path is a separate sibling block.

---
 rtl/psram_axi4_rd_slv_buf.sv | 205 ++++++++++++++++++++
 tb/tb_psram_axi4_rd_slv_buf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_axi4_rd_slv_buf.sv
// AXI4 read slave for the PSRAM user port: FIXED/INCR/WRAP bursts, range/protocol checks, FIFO-buffered R data.
// Latency: usr_rvalid_i -> rvalid one cycle. Backpressure: R stall fills the FIFO and new user requests stop on its credit.
module psram_axi4_rd_slv_buf #(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int USR_ADDR_SIZE = 64*1024*1024,
  parameter int FIFO_DEPTH    = 4,
  localparam int DATA_BLOG      = $clog2(DATA_WIDTH/8),
  localparam int USR_ADDR_WIDTH = $clog2(USR_ADDR_SIZE)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [ID_WIDTH-1:0]                 arid,
  input  logic [ADDR_WIDTH-1:0]               araddr,
  input  logic [7:0]                          arlen,
  input  logic [2:0]                          arsize,
  input  logic [1:0]                          arburst,
  input  logic                                arvalid,
  output logic                                arready,
  output logic [ID_WIDTH-1:0]                 rid,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic [1:0]                          rresp,
  output logic                                rlast,
  output logic                                rvalid,
  input  logic                                rready,
  output logic                                usr_xfer_start_o,
  output logic [7:0]                          usr_len_o,
  output logic [USR_ADDR_WIDTH-DATA_BLOG-1:0] usr_addr_o,
  input  logic [DATA_WIDTH-1:0]               usr_dat_i,
  input  logic                                usr_rvalid_i
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam int PW = $clog2(FIFO_DEPTH);

  state_t state, state_nxt;

  logic                                ready_en;
  logic [ID_WIDTH-1:0]                 id_q;
  addr_t                               addr_q;
  logic [7:0]                          len_q;
  logic [2:0]                          size_q;
  logic [1:0]                          burst_q;
  logic [1:0]                          resp_q;
  logic [8:0]                          issued;
  logic [8:0]                          returned;
  logic                                outstanding;
  logic                                start_q;
  logic [USR_ADDR_WIDTH-DATA_BLOG-1:0] uaddr_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_count;
  logic                  fifo_nonempty;

  logic [1:0]  chk_resp;
  logic [16:0] incr_end;
  addr_t       align_mask;
  addr_t       bytes, wmask, next_addr;
  logic        ar_hs, push, pop, err_hs, beat_last, credit, issue;

  assign ar_hs         = arvalid && (state == IDLE) && ready_en;
  assign fifo_nonempty = (fifo_count != '0);
  assign push          = usr_rvalid_i && outstanding && (state == RUN);
  assign pop           = (state == RUN) && fifo_nonempty && rready;
  assign err_hs        = (state == ERR) && rready;
  assign beat_last     = (returned == 9'(len_q));
  // One slot is reserved for the request about to be issued; a same-cycle push already holds its slot.
  assign credit        = (32'(fifo_count) + 32'(push) + 32'd1) <= 32'(FIFO_DEPTH);
  assign issue         = (state == RUN) && (!outstanding || push) &&
                         (issued < (9'(len_q) + 9'd1)) && credit;

  assign incr_end   = 17'(araddr[11:0]) + ((17'(arlen) + 17'd1) << arsize);
  assign align_mask = (addr_t'(1) << arsize) - addr_t'(1);

  always_comb begin
    chk_resp = 2'b00;
    if ((araddr >> USR_ADDR_WIDTH) != '0) begin
      chk_resp = 2'b11;
    end else if ((arburst == 2'b11) ||
                 (32'(arsize) > DATA_BLOG) ||
                 ((arburst == 2'b10) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                 ((arburst == 2'b10) && ((araddr & align_mask) != '0)) ||
                 ((arburst == 2'b01) && (incr_end > 17'd4096))) begin
      chk_resp = 2'b10;
    end
  end

  assign bytes = addr_t'(1) << size_q;
  assign wmask = ((addr_t'(len_q) + addr_t'(1)) << size_q) - addr_t'(1);

  always_comb begin
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(bytes - addr_t'(1))) + bytes;
      2'b10:   next_addr = (addr_q & ~wmask) | ((addr_q + bytes) & wmask);
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    case (state)
      IDLE: begin
        arready = ready_en;
        if (ar_hs) state_nxt = (chk_resp != 2'b00) ? ERR : RUN;
      end
      RUN: begin
        rvalid = fifo_nonempty;
        rdata  = fifo_nonempty ? mem[rd_ptr] : '0;
        rlast  = fifo_nonempty && beat_last;
        if (pop && beat_last) state_nxt = IDLE;
      end
      ERR: begin
        rvalid = 1'b1;
        rresp  = resp_q;
        rlast  = beat_last;
        if (err_hs && beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ready_en    <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      resp_q      <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= 1'b0;
      start_q     <= 1'b0;
      uaddr_q     <= '0;
    end else begin
      ready_en <= 1'b1;
      start_q  <= 1'b0;
      if (ar_hs) begin
        id_q        <= arid;
        addr_q      <= araddr;
        len_q       <= arlen;
        size_q      <= arsize;
        burst_q     <= arburst;
        resp_q      <= chk_resp;
        issued      <= '0;
        returned    <= '0;
        outstanding <= 1'b0;
        if (chk_resp == 2'b00) begin
          start_q     <= 1'b1;
          uaddr_q     <= araddr[USR_ADDR_WIDTH-1:DATA_BLOG];
          issued      <= 9'd1;
          outstanding <= 1'b1;
        end
      end else begin
        if (issue) begin
          start_q     <= 1'b1;
          addr_q      <= next_addr;
          uaddr_q     <= next_addr[USR_ADDR_WIDTH-1:DATA_BLOG];
          issued      <= issued + 9'd1;
          outstanding <= 1'b1;
        end else if (push) begin
          outstanding <= 1'b0;
        end
        if (pop || err_hs) returned <= returned + 9'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= usr_dat_i;
  end

  assign rid              = id_q;
  assign usr_xfer_start_o = start_q;
  assign usr_len_o        = len_q;
  assign usr_addr_o       = uaddr_q;

endmodule

// File: tb/tb_psram_axi4_rd_slv_buf.sv
// Directed bench for psram_axi4_rd_slv_buf: a user-side responder answers each request two cycles later.
module tb_psram_axi4_rd_slv_buf;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int UAW = 24;
  localparam logic [31:0] DBASE = 32'hDA00_0000;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [IW-1:0]  arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [7:0]     arlen = '0;
  logic [2:0]     arsize = '0;
  logic [1:0]     arburst = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IW-1:0]  rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready = 1'b0;
  logic           usr_xfer_start_o;
  logic [7:0]     usr_len_o;
  logic [UAW-1:0] usr_addr_o;
  logic [DW-1:0]  usr_dat_i = '0;
  logic           usr_rvalid_i = 1'b0;

  psram_axi4_rd_slv_buf dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .usr_xfer_start_o(usr_xfer_start_o), .usr_len_o(usr_len_o), .usr_addr_o(usr_addr_o),
    .usr_dat_i(usr_dat_i), .usr_rvalid_i(usr_rvalid_i)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;
  int rsp_cnt = 0;

  logic [DW-1:0]  q_dat[$];
  logic [1:0]     q_resp[$];
  logic           q_last[$];
  logic [IW-1:0]  q_id[$];
  logic [UAW-1:0] q_uaddr[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && rvalid && rready) begin
      q_dat.push_back(rdata);
      q_resp.push_back(rresp);
      q_last.push_back(rlast);
      q_id.push_back(rid);
    end
    if (usr_xfer_start_o) q_uaddr.push_back(usr_addr_o);
  end

  // User side: one response two cycles after each request pulse, data = DBASE + response index.
  initial begin
    forever begin
      @(negedge aclk);
      if (usr_xfer_start_o) begin
        @(posedge aclk);
        @(posedge aclk);
        #1;
        usr_rvalid_i = 1'b1;
        usr_dat_i    = DBASE + 32'(rsp_cnt);
        rsp_cnt++;
        @(posedge aclk);
        #1;
        usr_rvalid_i = 1'b0;
      end
    end
  end

  task automatic clear();
    q_dat.delete(); q_resp.delete(); q_last.delete(); q_id.delete(); q_uaddr.delete();
    rsp_cnt = 0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    int t;
    @(posedge aclk); #1;
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!arready && t < 50);
    chk("ar_accept", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_last(input int budget);
    int t;
    t = 0;
    do begin @(negedge aclk); t++; end while (!(rvalid && rready && rlast) && t < budget);
    chk("rlast_seen", rvalid && rready && rlast, 1);
    @(negedge aclk);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [1:0] resp,
                             input logic [IW-1:0] id, input logic err);
    chk($sformatf("%s_nbeats", tag), q_dat.size(), n);
    for (int i = 0; i < q_dat.size() && i < n; i++) begin
      chk($sformatf("%s_dat%0d", tag, i), q_dat[i], err ? 32'h0 : DBASE + 32'(i));
      chk($sformatf("%s_resp%0d", tag, i), q_resp[i], resp);
      chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1));
      chk($sformatf("%s_id%0d", tag, i), q_id[i], id);
    end
  endtask

  task automatic check_uaddr(input string tag, input int n, input logic [UAW-1:0] a0,
                             input logic [UAW-1:0] a1, input logic [UAW-1:0] a2, input logic [UAW-1:0] a3);
    logic [UAW-1:0] exp [4];
    exp = '{a0, a1, a2, a3};
    chk($sformatf("%s_nreq", tag), q_uaddr.size(), n);
    for (int i = 0; i < q_uaddr.size() && i < n && i < 4; i++)
      chk($sformatf("%s_ua%0d", tag, i), q_uaddr[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nlast;
    int bad;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_start", usr_xfer_start_o, 0);
    chk("rst_len", usr_len_o, 0);
    chk("rst_uaddr", usr_addr_o, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_arready_rel", arready, 1);

    // Basic INCR len=3 size=2 @0x100
    clear(); rready = 1'b1;
    send_ar(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    chk("t1_len", usr_len_o, 3);
    t = 0;
    do begin @(negedge aclk); t++; end while (!usr_rvalid_i && t < 20);
    chk("t1_usr_rvalid_seen", usr_rvalid_i, 1);
    chk("t1_pre_rvalid", rvalid, 0);
    @(negedge aclk);
    chk("t1_rvalid_lat", rvalid, 1);
    chk("t1_rdata_first", rdata, DBASE);
    wait_last(100);
    chk("t1_arready_after", arready, 1);
    chk("t1_rvalid_after", rvalid, 0);
    check_uaddr("t1", 4, 24'h40, 24'h41, 24'h42, 24'h43);
    check_beats("t1", 4, 2'b00, 4'd5, 1'b0);

    // WRAP len=3 size=2 @0x108
    clear();
    send_ar(4'd1, 32'h108, 8'd3, 3'd2, 2'b10);
    wait_last(100);
    check_uaddr("wrap", 4, 24'h42, 24'h43, 24'h40, 24'h41);
    check_beats("wrap", 4, 2'b00, 4'd1, 1'b0);

    // FIXED len=2 @0x20
    clear();
    send_ar(4'd2, 32'h20, 8'd2, 3'd2, 2'b00);
    wait_last(100);
    check_uaddr("fixed", 3, 24'h08, 24'h08, 24'h08, 24'h00);
    check_beats("fixed", 3, 2'b00, 4'd2, 1'b0);

    // Backpressure: INCR len=7 with R stalled
    clear(); rready = 1'b0;
    send_ar(4'd3, 32'h200, 8'd7, 3'd2, 2'b01);
    repeat (30) @(negedge aclk);
    chk("bp_nreq_stalled", q_uaddr.size(), 4);
    chk("bp_rvalid", rvalid, 1);
    chk("bp_rdata", rdata, DBASE);
    chk("bp_rlast", rlast, 0);
    repeat (3) @(negedge aclk);
    chk("bp_rdata_held", rdata, DBASE);
    chk("bp_rid_held", rid, 3);
    rready = 1'b1;
    wait_last(200);
    chk("bp_nreq", q_uaddr.size(), 8);
    for (int i = 0; i < q_uaddr.size() && i < 8; i++)
      chk($sformatf("bp_ua%0d", i), q_uaddr[i], 24'h80 + 24'(i));
    check_beats("bp", 8, 2'b00, 4'd3, 1'b0);

    // DECERR: out of PSRAM range
    clear();
    send_ar(4'd4, 32'h0400_0000, 8'd1, 3'd2, 2'b01);
    wait_last(50);
    chk("dec_nreq", q_uaddr.size(), 0);
    check_beats("dec", 2, 2'b11, 4'd4, 1'b1);

    // SLVERR: reserved burst type
    clear();
    send_ar(4'd6, 32'h0, 8'd0, 3'd2, 2'b11);
    wait_last(50);
    chk("rsv_nreq", q_uaddr.size(), 0);
    check_beats("rsv", 1, 2'b10, 4'd6, 1'b1);

    // SLVERR: INCR crossing 4 KiB
    clear();
    send_ar(4'd7, 32'hFFC, 8'd1, 3'd2, 2'b01);
    wait_last(50);
    chk("x4k_nreq", q_uaddr.size(), 0);
    check_beats("x4k", 2, 2'b10, 4'd7, 1'b1);

    // SLVERR: WRAP with illegal length
    clear();
    send_ar(4'd8, 32'h0, 8'd2, 3'd2, 2'b10);
    wait_last(50);
    check_beats("wlen", 3, 2'b10, 4'd8, 1'b1);

    // SLVERR: size wider than the data bus
    clear();
    send_ar(4'd9, 32'h0, 8'd0, 3'd3, 2'b01);
    wait_last(50);
    check_beats("wide", 1, 2'b10, 4'd9, 1'b1);

    // Max length INCR len=255
    clear();
    send_ar(4'd10, 32'h0, 8'd255, 3'd2, 2'b01);
    wait_last(3000);
    chk("max_nreq", q_uaddr.size(), 256);
    bad = 0;
    for (int i = 0; i < q_uaddr.size(); i++)
      if (q_uaddr[i] !== 24'(i)) bad++;
    chk("max_uaddr_bad", bad, 0);
    nlast = 0;
    for (int i = 0; i < q_last.size(); i++)
      if (q_last[i]) nlast++;
    chk("max_nlast", nlast, 1);
    check_beats("max", 256, 2'b00, 4'd10, 1'b0);

    // Reset during beat 2 of INCR len=3
    clear();
    send_ar(4'd11, 32'h0, 8'd3, 3'd2, 2'b01);
    t = 0;
    do begin @(negedge aclk); t++; end while (!(rvalid && rready) && t < 20);
    chk("rstm_beat1", rvalid && rready, 1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("rstm_rvalid", rvalid, 0);
    chk("rstm_arready", arready, 0);
    chk("rstm_start", usr_xfer_start_o, 0);
    aresetn = 1'b1;
    q_dat.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
    @(posedge aclk); #1;
    chk("rstm_arready_rel", arready, 1);
    repeat (8) @(negedge aclk);
    chk("rstm_stray_ignored", q_dat.size(), 0);
    chk("rstm_rvalid_idle", rvalid, 0);
    clear();
    send_ar(4'd12, 32'h40, 8'd0, 3'd2, 2'b01);
    wait_last(50);
    check_uaddr("rstm", 1, 24'h10, 24'h0, 24'h0, 24'h0);
    check_beats("rstm", 1, 2'b00, 4'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
